// File: rtl/line_drawer_if.sv
// Pixel-request bus between a line_drawer and whatever drives it.
// The master issues draw requests and watches busy/done; the slave (the
// rasteriser) produces the pixel write stream that feeds vga_core.
interface line_drawer_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int C_W = 3
);
  logic           start;
  logic [X_W-1:0] x0;
  logic [Y_W-1:0] y0;
  logic [X_W-1:0] x1;
  logic [Y_W-1:0] y1;
  logic [C_W-1:0] color_in;
  logic           busy;
  logic           done;
  logic           plot;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [C_W-1:0] color;

  modport master (
    output start, x0, y0, x1, y1, color_in,
    input  busy, done, plot, x, y, color
  );

  modport slave (
    input  start, x0, y0, x1, y1, color_in,
    output busy, done, plot, x, y, color
  );
endinterface

// File: rtl/line_drawer.sv
// Bresenham line rasteriser feeding vga_core: one pixel write per clock
// from (x0,y0) to (x1,y1) inclusive, then a one-cycle done pulse.
// Optional macro LINE_CLIP_EN: suppresses plot for points outside
// H_RES x V_RES without changing stepping or timing.
module line_drawer #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int C_W   = 3,
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic         clk,
  input  logic         reset,
  line_drawer_if.slave bus
);
  localparam int AW = ((X_W > Y_W) ? X_W : Y_W) + 2;

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

  state_t state, state_n;

  // Latched request
  logic [X_W-1:0] x0_l, x0_n, x1_l, x1_n;
  logic [Y_W-1:0] y0_l, y0_n, y1_l, y1_n;
  logic [C_W-1:0] c_l, c_n;

  // Bresenham terms
  logic signed [AW-1:0] dx_r, dx_n, dy_r, dy_n, err_r, err_n;
  logic signed [AW-1:0] ddx, ddy;
  logic signed [AW:0]   e2, dx_e, dy_e;
  logic                 sx_neg, sx_neg_n, sy_neg, sy_neg_n;

  // Registered outputs; x_r/y_r double as the current point
  logic           busy_r, busy_n, done_r, done_n, plot_r, plot_n;
  logic [X_W-1:0] x_r, x_n;
  logic [Y_W-1:0] y_r, y_n;
  logic [C_W-1:0] color_r, color_n;

`ifdef LINE_CLIP_EN
  function automatic logic in_view(logic [X_W-1:0] px, logic [Y_W-1:0] py);
    return (int'(px) < H_RES) && (int'(py) < V_RES);
  endfunction
`endif

  // Next-state, datapath step and output decode
  always_comb begin
    state_n  = state;
    x0_n     = x0_l;
    y0_n     = y0_l;
    x1_n     = x1_l;
    y1_n     = y1_l;
    c_n      = c_l;
    dx_n     = dx_r;
    dy_n     = dy_r;
    err_n    = err_r;
    sx_neg_n = sx_neg;
    sy_neg_n = sy_neg;
    x_n      = x_r;
    y_n      = y_r;
    color_n  = color_r;
    ddx  = $signed({{(AW-X_W){1'b0}}, x1_l}) - $signed({{(AW-X_W){1'b0}}, x0_l});
    ddy  = $signed({{(AW-Y_W){1'b0}}, y1_l}) - $signed({{(AW-Y_W){1'b0}}, y0_l});
    e2   = $signed({err_r, 1'b0});
    dx_e = $signed({dx_r[AW-1], dx_r});
    dy_e = $signed({dy_r[AW-1], dy_r});
    case (state)
      IDLE: begin
        if (bus.start) begin
          x0_n    = bus.x0;
          y0_n    = bus.y0;
          x1_n    = bus.x1;
          y1_n    = bus.y1;
          c_n     = bus.color_in;
          state_n = INIT;
        end
      end
      INIT: begin
        dx_n     = ddx[AW-1] ? -ddx : ddx;
        dy_n     = ddy[AW-1] ? ddy : -ddy;
        sx_neg_n = !(x0_l < x1_l);
        sy_neg_n = !(y0_l < y1_l);
        err_n    = dx_n + dy_n;
        x_n      = x0_l;
        y_n      = y0_l;
        color_n  = c_l;
        state_n  = DRAW;
      end
      DRAW: begin
        if (x_r == x1_l && y_r == y1_l) begin
          state_n = DONE;
        end else begin
          if (e2 >= dy_e) begin
            err_n = err_n + dy_r;
            x_n   = sx_neg ? x_r - 1'b1 : x_r + 1'b1;
          end
          if (e2 <= dx_e) begin
            err_n = err_n + dx_r;
            y_n   = sy_neg ? y_r - 1'b1 : y_r + 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
`ifdef LINE_CLIP_EN
    plot_n = (state_n == DRAW) && in_view(x_n, y_n);
`else
    plot_n = (state_n == DRAW);
`endif
  end

  // Control state and visible outputs, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      plot_r  <= 1'b0;
      x_r     <= '0;
      y_r     <= '0;
      color_r <= '0;
    end else begin
      state   <= state_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      plot_r  <= plot_n;
      x_r     <= x_n;
      y_r     <= y_n;
      color_r <= color_n;
    end
  end

  // Request latch and error terms; only meaningful once INIT has run
  always_ff @(posedge clk) begin
    x0_l   <= x0_n;
    y0_l   <= y0_n;
    x1_l   <= x1_n;
    y1_l   <= y1_n;
    c_l    <= c_n;
    dx_r   <= dx_n;
    dy_r   <= dy_n;
    err_r  <= err_n;
    sx_neg <= sx_neg_n;
    sy_neg <= sy_neg_n;
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.plot  = plot_r;
  assign bus.x     = x_r;
  assign bus.y     = y_r;
  assign bus.color = color_r;
endmodule

// File: tb/tb_line_drawer.sv
// Bench for line_drawer: directed lines from the test plan plus random
// lines, each compared cycle by cycle against a behavioural Bresenham model.
module tb_line_drawer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  line_drawer_if #(.X_W(8), .Y_W(7), .C_W(3)) bus ();

  line_drawer #(.X_W(8), .Y_W(7), .C_W(3), .H_RES(160), .V_RES(120)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_x[$];
  int exp_y[$];

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit ref_visible(input int px, input int py);
`ifdef LINE_CLIP_EN
    return (px < 160) && (py < 120);
`else
    return (px >= 0) && (py >= 0);
`endif
  endfunction

  // Integer Bresenham: list of points from (ax,ay) to (bx,by) inclusive
  task automatic ref_line(input int ax, input int ay, input int bx, input int by);
    int px, py, ddx, ddy, stx, sty, err, e2;
    exp_x.delete();
    exp_y.delete();
    px  = ax;
    py  = ay;
    ddx = (bx > ax) ? bx - ax : ax - bx;
    ddy = (by > ay) ? ay - by : by - ay;
    stx = (ax < bx) ? 1 : -1;
    sty = (ay < by) ? 1 : -1;
    err = ddx + ddy;
    forever begin
      exp_x.push_back(px);
      exp_y.push_back(py);
      if (px == bx && py == by) break;
      e2 = 2 * err;
      if (e2 >= ddy) begin err += ddy; px += stx; end
      if (e2 <= ddx) begin err += ddx; py += sty; end
    end
  endtask

  task automatic draw(input int ax, input int ay, input int bx, input int by,
                      input int c, input bit poke);
    int n;
    ref_line(ax, ay, bx, by);
    n = exp_x.size();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.x0       = 8'(ax);
    bus.y0       = 7'(ay);
    bus.x1       = 8'(bx);
    bus.y1       = 7'(by);
    bus.color_in = 3'(c);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("init_busy", int'(bus.busy), 1);
    check("init_plot", int'(bus.plot), 0);
    if (poke) begin
      bus.start = 1'b1;
      bus.x0    = 8'(ax + 40);
      bus.x1    = 8'(bx + 40);
      bus.y1    = 7'(by + 9);
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("draw_plot", int'(bus.plot), int'(ref_visible(exp_x[i], exp_y[i])));
      check("draw_x", int'(bus.x), exp_x[i]);
      check("draw_y", int'(bus.y), exp_y[i]);
      check("draw_color", int'(bus.color), c);
      check("draw_busy", int'(bus.busy), 1);
      check("draw_done", int'(bus.done), 0);
    end
    @(posedge clk); #1;
    check("done_done", int'(bus.done), 1);
    check("done_plot", int'(bus.plot), 0);
    check("done_busy", int'(bus.busy), 1);
    @(posedge clk); #1;
    check("idle_busy", int'(bus.busy), 0);
    check("idle_done", int'(bus.done), 0);
    check("idle_plot", int'(bus.plot), 0);
    if (poke) begin
      repeat (3) begin
        @(posedge clk); #1;
        check("poke_plot", int'(bus.plot), 0);
        check("poke_busy", int'(bus.busy), 0);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.x0       = '0;
    bus.y0       = '0;
    bus.x1       = '0;
    bus.y1       = '0;
    bus.color_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_plot", int'(bus.plot), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_x", int'(bus.x), 0);
    check("rst_y", int'(bus.y), 0);
    check("rst_color", int'(bus.color), 0);
    @(negedge clk);
    reset = 1'b0;

    draw(10, 5, 14, 5, 2, 1'b0);
    draw(3, 2, 5, 8, 6, 1'b0);
    draw(14, 5, 10, 5, 1, 1'b0);
    draw(7, 9, 7, 4, 7, 1'b0);
    draw(0, 0, 0, 0, 4, 1'b1);
    draw(159, 119, 0, 0, 3, 1'b1);

    // Reset in the middle of a long line
    @(negedge clk);
    bus.start    = 1'b1;
    bus.x0       = 8'd0;
    bus.y0       = 7'd0;
    bus.x1       = 8'd159;
    bus.y1       = 7'd119;
    bus.color_in = 3'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_plot", int'(bus.plot), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_done", int'(bus.done), 0);
    check("mid_rst_x", int'(bus.x), 0);
    check("mid_rst_y", int'(bus.y), 0);
    check("mid_rst_color", int'(bus.color), 0);
    reset = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("post_rst_plot", int'(bus.plot), 0);
      check("post_rst_busy", int'(bus.busy), 0);
    end

    draw(155, 5, 165, 5, 2, 1'b0);

    for (int k = 0; k < 25; k++) begin
      draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 7)), k[2]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/line_drawer.md
Name: line_drawer

Overview:
- Bresenham line rasteriser that sits directly upstream of vga_core, in the same slot the screen-fill generator occupies.
- Accepts two endpoints and a colour, then emits one pixel write (plot, x, y, color) per clock until the line is complete.
- Coordinates target the 160x120, 3-bit-colour frame buffer behind vga_core; outputs connect straight to its x/y/color/plot inputs.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- C_W, 3, colour width
- H_RES, 160, visible columns (used by clipping option)
- V_RES, 120, visible rows (used by clipping option)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request to draw; sampled only in IDLE
- x0  in  X_W  start column
- y0  in  Y_W  start row
- x1  in  X_W  end column
- y1  in  Y_W  end row
- color_in  in  C_W  line colour
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse after the last pixel
- plot  out  1  pixel write strobe to vga_core
- x  out  X_W  pixel column
- y  out  Y_W  pixel row
- color  out  C_W  pixel colour

Behaviour:
- All outputs are registered. Reset forces state IDLE and busy=done=plot=0, x=y=color=0.
- Reset takes priority over everything, including mid-line: the next cycle is IDLE with no further plots.
- FSM states: IDLE, INIT, DRAW, DONE.
- IDLE: if start=1 at a clock edge, latch x0, y0, x1, y1 and color_in, then go to INIT. Inputs are don't-care after latching.
- INIT (1 cycle): compute the following, then go to DRAW.
  - dx = |x1-x0|
  - dy = -|y1-y0|
  - sx = +1 if x0<x1, else -1
  - sy = +1 if y0<y1, else -1
  - err = dx+dy
  - current point = (x0,y0)
- DRAW (one pixel per cycle): plot=1 with x/y equal to the current point and color equal to the latched colour.
  - If the current point equals (x1,y1), go to DONE.
  - Otherwise, with e2 = 2*err:
    - if e2 >= dy: err += dy and x += sx
    - if e2 <= dx: err += dx and y += sy
    - Both conditions may hold in the same cycle; apply both updates (err += dx+dy).
- DONE (1 cycle): done=1, plot=0, busy=1; go to IDLE next cycle.
- Arithmetic widths:
  - dx, dy and err are signed, max(X_W,Y_W)+2 bits; e2 is signed, max(X_W,Y_W)+3 bits.
  - The point registers never wrap, because stepping stops at the endpoint.
- Timing:
  - start sampled at edge k: INIT occupies cycle k+1; the first plot is in cycle k+2.
  - The line produces N = max(dx,|dy|)+1 consecutive plot cycles, then one done cycle.
  - busy is high for N+2 cycles.
- start while busy: ignored, no queueing. start held high in the done cycle is also ignored; it is accepted in the following IDLE cycle.
- Degenerate line with (x0,y0)=(x1,y1): exactly one plot, then done.
- Any direction (all octants) must be supported. Endpoints are always plotted.

Optional Feature:
- Macro: LINE_CLIP_EN
- Defined: in DRAW, plot is forced to 0 for points with x >= H_RES or y >= V_RES. Stepping, cycle count, busy and done timing are unchanged.
- Undefined: every point is plotted; range checking is left to vga_core.

Test Plan:
- Reset, then start with (10,5)->(14,5) and colour 3'b010 -> plot high for 5 consecutive cycles starting 2 cycles after start, x=10..14, y=5, color=2; done pulses the next cycle; busy high for 7 cycles.
- Steep line (3,2)->(5,8) -> 7 plots in order: (3,2), (3,3), (4,4), (4,5), (4,6), (5,7), (5,8); then done.
- Reverse-direction line (14,5)->(10,5) and vertical line (7,9)->(7,4) -> 5 and 6 plots respectively, strictly decreasing x or y, endpoints included.
- Single point (0,0)->(0,0) -> one plot at (0,0), then done; a second start pulsed during busy -> no extra plots.
- Assert reset during DRAW of (0,0)->(159,119) -> plot, busy, done, x, y and color are all 0 the cycle after reset; no plots until the next start.
- With LINE_CLIP_EN defined, draw (155,5)->(165,5) -> plots only x=155..159; done occurs after 11 DRAW cycles.
